// File: rtl/seq_mod_pkg.sv
// Shared definitions for the sequential modulo engine.
//   state_t : FSM state encoding (IDLE/CALC/ZERO/DONE)
//   OP_MOD  : ALU opcode that selects this engine, shared with the op decoder
package seq_mod_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        ZERO = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [2:0] OP_MOD = 3'b111;

endpackage

// File: rtl/seq_mod_unit_if.sv
// Request/response bundle between the ALU decoder and the modulo engine.
//   master : drives start, a, b; observes ready, busy, done, result, div_zero
//   slave  : the engine side
interface seq_mod_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             div_zero;

    modport master (
        output start, a, b,
        input  ready, busy, done, result, div_zero
    );

    modport slave (
        input  start, a, b,
        output ready, busy, done, result, div_zero
    );
endinterface

// File: rtl/seq_mod_unit_mod_step.sv
// One restoring shift-subtract step of the modulo iteration.
//   rem     : current partial remainder (WIDTH+1 bits)
//   dvd_msb : next dividend bit shifted into the remainder
//   b       : divisor
//   rem_nxt : partial remainder after the conditional subtract
module mod_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem,
    input  logic             dvd_msb,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH:0]   rem_nxt
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] b_ext;

    always_comb begin
        // rem < b always holds between steps, so the shifted value stays
        // below 2*b and fits in WIDTH+1 bits even for b >= 2^(WIDTH-1).
        shifted = (rem << 1) | {{WIDTH{1'b0}}, dvd_msb};
        b_ext   = {1'b0, b};
        rem_nxt = (shifted >= b_ext) ? (shifted - b_ext) : shifted;
    end
endmodule

// File: rtl/seq_mod_unit.sv
// Sequential unsigned a mod b engine, one dividend bit per cycle.
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   bus     : slave side of seq_mod_unit_if (start/a/b in; ready, busy,
//             done, result, div_zero out)
// Normal path: WIDTH CALC cycles, done pulses in cycle WIDTH+1 after accept.
// b==0 path:   one ZERO cycle, done pulses in cycle 2 with result=a.
module seq_mod_unit
    import seq_mod_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic           clk,
    input  logic           reset_n,
    seq_mod_unit_if.slave  bus
);
    state_t           state;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] div_b;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   rem_nxt;

    logic             ready_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] result_q;
    logic             div_zero_q;

    mod_step #(.WIDTH(WIDTH)) u_step (
        .rem     (rem),
        .dvd_msb (dvd[WIDTH-1]),
        .b       (div_b),
        .rem_nxt (rem_nxt)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            rem        <= '0;
            dvd        <= '0;
            div_b      <= '0;
            cnt        <= '0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            div_zero_q <= 1'b0;
        end else begin
            case (state)
                // DONE accepts start exactly like IDLE for back-to-back ops.
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        // a is kept in dvd on the ZERO path too; it becomes
                        // the result there.
                        dvd     <= bus.a;
                        div_b   <= bus.b;
                        rem     <= '0;
                        cnt     <= '0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state   <= (bus.b != '0) ? CALC : ZERO;
                    end else begin
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state   <= IDLE;
                    end
                end
                CALC: begin
                    rem <= rem_nxt;
                    dvd <= dvd << 1;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        result_q   <= rem_nxt[WIDTH-1:0];
                        div_zero_q <= 1'b0;
                        done_q     <= 1'b1;
                        ready_q    <= 1'b1;
                        busy_q     <= 1'b0;
                        state      <= DONE;
                    end
                end
                ZERO: begin
                    result_q   <= dvd;
                    div_zero_q <= 1'b1;
                    done_q     <= 1'b1;
                    ready_q    <= 1'b1;
                    busy_q     <= 1'b0;
                    state      <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ready    = ready_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.div_zero = div_zero_q;
endmodule
